// File: rtl/mips_pkg.sv
// Shared MIPS core types and constants: instruction width, the NOP encoding and
// the IF/ID pipeline-register layout consumed by decode.
package mips_pkg;

  localparam int INSTR_W = 32;
  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [31:0]        pc;
    logic [31:0]        pc_plus4;
    logic               valid;
    logic               misalign;
  } if_id_t;

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory port of the fetch stage: a word index out, the instruction
// word back combinationally in the same cycle (no handshake, always ready).
interface fetch_stage_if;
  import mips_pkg::*;

  logic [31:0]        imem_addr;
  logic [INSTR_W-1:0] imem_data;

  modport master (output imem_addr, input imem_data);
  modport slave  (input imem_addr, output imem_data);

endinterface

// File: rtl/pc_reg.sv
// Program counter with next-PC selection (redirect > stall > advance) and the
// pending-misalign flag that rides with the first fetch after a redirect.
module pc_reg
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        capture,
  output logic [31:0] pc,
  output logic        misalign_pend
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc            <= RESET_PC;
      misalign_pend <= 1'b0;
    end else if (redirect_valid) begin
      // Low bits are dropped from the fetch address but remembered for decode.
      pc            <= {redirect_pc[31:2], 2'b00};
      misalign_pend <= |redirect_pc[1:0];
    end else begin
      if (!stall) pc <= pc + 32'd4;
      if (capture) misalign_pend <= 1'b0;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// MIPS instruction-fetch stage: PC, instruction-memory addressing and IF/ID register.
// Define IF_PERF_CNT_EN to add the fetch_cnt / stall_cnt performance counters.
module fetch_stage
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          IMEM_WORDS = 1024
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               stall,
  input  logic               flush,
  input  logic               redirect_valid,
  input  logic [31:0]        redirect_pc,
  fetch_stage_if.master      imem,
  output logic [31:0]        pc,
  output logic [INSTR_W-1:0] id_instr,
  output logic [31:0]        id_pc,
  output logic [31:0]        id_pc_plus4,
  output logic               id_valid,
  output logic               id_misalign
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0]        fetch_cnt,
  output logic [31:0]        stall_cnt
`endif
);

  localparam logic [31:0] IDX_MASK = 32'(IMEM_WORDS - 1);

  logic   misalign_pend;
  logic   bubble;
  logic   capture;
  if_id_t if_id;

  assign bubble  = redirect_valid | flush;
  assign capture = !bubble && !stall;

  pc_reg #(.RESET_PC(RESET_PC)) u_pc_reg (
    .clk           (clk),
    .rst_n         (rst_n),
    .stall         (stall),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .capture       (capture),
    .pc            (pc),
    .misalign_pend (misalign_pend)
  );

  // Word index; PCs beyond the memory depth alias back into it.
  assign imem.imem_addr = {2'b00, pc[31:2]} & IDX_MASK;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      if_id <= '{instr: NOP_INSTR, pc: 32'h0, pc_plus4: 32'h0, valid: 1'b0, misalign: 1'b0};
    end else if (bubble) begin
      // id_pc / id_pc_plus4 deliberately keep their last values across a bubble.
      if_id.instr    <= NOP_INSTR;
      if_id.valid    <= 1'b0;
      if_id.misalign <= 1'b0;
    end else if (!stall) begin
      if_id <= '{instr: imem.imem_data, pc: pc, pc_plus4: pc + 32'd4,
                 valid: 1'b1, misalign: misalign_pend};
    end
  end

  assign id_instr    = if_id.instr;
  assign id_pc       = if_id.pc;
  assign id_pc_plus4 = if_id.pc_plus4;
  assign id_valid    = if_id.valid;
  assign id_misalign = if_id.misalign;

`ifdef IF_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fetch_cnt <= 32'h0;
      stall_cnt <= 32'h0;
    end else begin
      if (capture) fetch_cnt <= fetch_cnt + 32'd1;
      if (stall && !redirect_valid) stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed vector table, randomized run against a
// reference model, and a wrap-around sequence on a second instance.
module tb_fetch_stage;
  import mips_pkg::*;

  localparam bit O = 1'b0;
  localparam bit I = 1'b1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n = 1'b0;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;

  logic [31:0] mem [1024];

  logic [31:0] pc0, id_instr0, id_pc0, id_pp40;
  logic        id_valid0, id_mis0;
  logic [31:0] pc1, id_instr1, id_pc1, id_pp41;
  logic        id_valid1, id_mis1;
`ifdef IF_PERF_CNT_EN
  logic [31:0] fc0, sc0, fc1, sc1;
`endif

  fetch_stage_if bus0 ();
  fetch_stage_if bus1 ();
  assign bus0.imem_data = mem[bus0.imem_addr[9:0]];
  assign bus1.imem_data = mem[bus1.imem_addr[9:0]];

  fetch_stage #(.RESET_PC(32'h0000_0000), .IMEM_WORDS(1024)) dut0 (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .imem(bus0.master),
    .pc(pc0), .id_instr(id_instr0), .id_pc(id_pc0), .id_pc_plus4(id_pp40),
    .id_valid(id_valid0), .id_misalign(id_mis0)
`ifdef IF_PERF_CNT_EN
    , .fetch_cnt(fc0), .stall_cnt(sc0)
`endif
  );

  fetch_stage #(.RESET_PC(32'hFFFF_FFFC), .IMEM_WORDS(1024)) dut1 (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .imem(bus1.master),
    .pc(pc1), .id_instr(id_instr1), .id_pc(id_pc1), .id_pc_plus4(id_pp41),
    .id_valid(id_valid1), .id_misalign(id_mis1)
`ifdef IF_PERF_CNT_EN
    , .fetch_cnt(fc1), .stall_cnt(sc1)
`endif
  );

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- driver ----------------
  task automatic drive(input logic r, input logic st, input logic fl,
                       input logic rv, input logic [31:0] rpc);
    rst_n = r; stall = st; flush = fl; redirect_valid = rv; redirect_pc = rpc;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- reference model ----------------
  logic [31:0] m_pc, m_instr, m_idpc, m_pp4, m_fc, m_sc;
  logic        m_pend, m_valid, m_mis;

  task automatic model_step(input logic r, input logic st, input logic fl,
                            input logic rv, input logic [31:0] rpc);
    logic [31:0] word;
    int idx;
    if (!r) begin
      m_pc = 32'h0; m_pend = 1'b0; m_instr = 32'h0; m_idpc = 32'h0; m_pp4 = 32'h0;
      m_valid = 1'b0; m_mis = 1'b0; m_fc = 32'h0; m_sc = 32'h0;
    end else begin
      idx  = int'((m_pc / 32'd4) % 32'd1024);
      word = mem[idx];
      if (rv || fl) begin
        m_instr = 32'h0; m_valid = 1'b0; m_mis = 1'b0;
      end else if (!st) begin
        m_instr = word; m_idpc = m_pc; m_pp4 = m_pc + 32'd4;
        m_valid = 1'b1; m_mis = m_pend; m_pend = 1'b0;
        m_fc = m_fc + 32'd1;
      end
      if (st && !rv) m_sc = m_sc + 32'd1;
      if (rv) begin
        m_pc   = rpc - (rpc % 32'd4);
        m_pend = (rpc % 32'd4) != 32'd0;
      end else if (!st) begin
        m_pc = m_pc + 32'd4;
      end
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        r, st, fl, rv;
    logic [31:0] rpc;
    logic [31:0] pc;
    logic        valid;
    logic [31:0] idpc;
    logic [31:0] instr;
    logic        mis;
  } vec_t;

  function automatic vec_t mk(input logic r, input logic st, input logic fl, input logic rv,
                              input logic [31:0] rpc, input logic [31:0] epc, input logic v,
                              input logic [31:0] idpc, input logic [31:0] instr, input logic mis);
    vec_t t;
    t.r = r; t.st = st; t.fl = fl; t.rv = rv; t.rpc = rpc;
    t.pc = epc; t.valid = v; t.idpc = idpc; t.instr = instr; t.mis = mis;
    return t;
  endfunction

  vec_t vecs[21];

  initial begin
    logic [31:0] eaddr;
    logic [31:0] rpc;
    logic        r, st, fl, rv;

    for (int k = 0; k < 1024; k++) mem[k] = 32'hA500_0000 | 32'(k);
    mem[4] = 32'd32;
    mem[5] = 32'd456;

    vecs[0]  = mk(O,O,O,O, 32'h0,  32'h00, O, 32'h00, 32'h0,   O);
    vecs[1]  = mk(O,O,O,O, 32'h0,  32'h00, O, 32'h00, 32'h0,   O);
    vecs[2]  = mk(I,O,O,O, 32'h0,  32'h04, I, 32'h00, mem[0],  O);
    vecs[3]  = mk(I,O,O,O, 32'h0,  32'h08, I, 32'h04, mem[1],  O);
    vecs[4]  = mk(I,I,O,O, 32'h0,  32'h08, I, 32'h04, mem[1],  O);
    vecs[5]  = mk(I,I,O,O, 32'h0,  32'h08, I, 32'h04, mem[1],  O);
    vecs[6]  = mk(I,I,O,O, 32'h0,  32'h08, I, 32'h04, mem[1],  O);
    vecs[7]  = mk(I,O,O,O, 32'h0,  32'h0C, I, 32'h08, mem[2],  O);
    vecs[8]  = mk(I,O,O,O, 32'h0,  32'h10, I, 32'h0C, mem[3],  O);
    vecs[9]  = mk(I,O,O,O, 32'h0,  32'h14, I, 32'h10, 32'd32,  O);
    vecs[10] = mk(I,O,O,O, 32'h0,  32'h18, I, 32'h14, 32'd456, O);
    vecs[11] = mk(I,I,O,I, 32'h40, 32'h40, O, 32'h14, 32'h0,   O);
    vecs[12] = mk(I,O,O,O, 32'h0,  32'h44, I, 32'h40, mem[16], O);
    vecs[13] = mk(I,O,O,I, 32'h23, 32'h20, O, 32'h40, 32'h0,   O);
    vecs[14] = mk(I,O,O,O, 32'h0,  32'h24, I, 32'h20, mem[8],  I);
    vecs[15] = mk(I,O,O,O, 32'h0,  32'h28, I, 32'h24, mem[9],  O);
    vecs[16] = mk(I,O,I,O, 32'h0,  32'h2C, O, 32'h24, 32'h0,   O);
    vecs[17] = mk(I,O,O,O, 32'h0,  32'h30, I, 32'h2C, mem[11], O);
    vecs[18] = mk(I,I,I,O, 32'h0,  32'h30, O, 32'h2C, 32'h0,   O);
    vecs[19] = mk(O,O,O,O, 32'h0,  32'h00, O, 32'h00, 32'h0,   O);
    vecs[20] = mk(I,O,O,O, 32'h0,  32'h04, I, 32'h00, mem[0],  O);

    // Directed vectors: inputs applied before the edge, outputs checked after it.
    for (int i = 0; i < 21; i++) begin
      drive(vecs[i].r, vecs[i].st, vecs[i].fl, vecs[i].rv, vecs[i].rpc);
      tick();
      eaddr = (vecs[i].pc / 32'd4) % 32'd1024;
      check($sformatf("v%0d pc", i),       pc0,            vecs[i].pc);
      check($sformatf("v%0d imem_addr", i), bus0.imem_addr, eaddr);
      check($sformatf("v%0d id_valid", i), 32'(id_valid0),  32'(vecs[i].valid));
      check($sformatf("v%0d id_pc", i),    id_pc0,         vecs[i].idpc);
      check($sformatf("v%0d id_instr", i), id_instr0,      vecs[i].instr);
      check($sformatf("v%0d id_misalign", i), 32'(id_mis0), 32'(vecs[i].mis));
`ifdef IF_PERF_CNT_EN
      if (i == 6) check("stall_cnt after 3 stalls", sc0, 32'd3);
`endif
    end

    // Randomized run against the reference model.
    for (int k = 0; k < 1024; k++) mem[k] = $urandom();
    for (int i = 0; i < 600; i++) begin
      r   = (i < 2) ? 1'b0 : ($urandom_range(0, 49) != 0);
      st  = ($urandom_range(0, 3) == 0);
      fl  = ($urandom_range(0, 9) == 0);
      rv  = ($urandom_range(0, 6) == 0);
      rpc = ($urandom_range(0, 3) == 0) ? $urandom() : 32'($urandom_range(0, 8191));
      model_step(r, st, fl, rv, rpc);
      drive(r, st, fl, rv, rpc);
      tick();
      check("rnd pc",          pc0,            m_pc);
      check("rnd imem_addr",   bus0.imem_addr, (m_pc / 32'd4) % 32'd1024);
      check("rnd id_instr",    id_instr0,      m_instr);
      check("rnd id_pc",       id_pc0,         m_idpc);
      check("rnd id_pc_plus4", id_pp40,        m_pp4);
      check("rnd id_valid",    32'(id_valid0), 32'(m_valid));
      check("rnd id_misalign", 32'(id_mis0),   32'(m_mis));
`ifdef IF_PERF_CNT_EN
      check("rnd fetch_cnt",   fc0,            m_fc);
      check("rnd stall_cnt",   sc0,            m_sc);
`endif
    end

    // Wrap-around on the instance that resets to the last word of the address space.
    drive(O, O, O, O, 32'h0);
    tick();
    tick();
    check("wrap reset pc",        pc1,            32'hFFFF_FFFC);
    check("wrap reset imem_addr", bus1.imem_addr, 32'd1023);
    check("wrap reset id_valid",  32'(id_valid1), 32'd0);
    drive(I, O, O, O, 32'h0);
    tick();
    check("wrap pc",          pc1,            32'h0);
    check("wrap imem_addr",   bus1.imem_addr, 32'h0);
    check("wrap id_pc",       id_pc1,         32'hFFFF_FFFC);
    check("wrap id_pc_plus4", id_pp41,        32'h0);
    check("wrap id_instr",    id_instr1,      mem[1023]);
    check("wrap id_valid",    32'(id_valid1), 32'd1);
    drive(I, O, I, O, 32'h0);
    tick();
    check("flush pc",       pc1,            32'h4);
    check("flush id_valid", 32'(id_valid1), 32'd0);
    check("flush id_instr", id_instr1,      32'h0);
    check("flush id_pc",    id_pc1,         32'hFFFF_FFFC);
    drive(I, O, O, O, 32'h0);
    tick();
    check("after flush pc",       pc1,            32'h8);
    check("after flush id_pc",    id_pc1,         32'h4);
    check("after flush id_instr", id_instr1,      mem[1]);
    check("after flush id_valid", 32'(id_valid1), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
